data_mem_initiator: RTL and testbench

//  Load/store initiator: accepts one load/store per request from the pipeline (valid/ready) and drives the data

---
 rtl/data_mem_initiator_if.sv | 33 +++
 rtl/data_mem_initiator.sv | 152 +++++++++++++++
 tb/tb_data_mem_initiator.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_initiator_if.sv
// Pipeline load/store request/response channel plus the data-memory port, bundled for data_mem_initiator.
// master is the initiator's view; slave is the pipeline/memory environment's view.
interface data_mem_initiator_if;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [2:0]    req_funct3;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] addr;
    logic [DW-1:0] write_data;
    logic          memread;
    logic          memwrite;
    logic [3:0]    sign_mask;
    logic [DW-1:0] read_data;
    logic          clk_stall;

    modport master (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, read_data, clk_stall,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, addr, write_data, memread, memwrite, sign_mask
    );

    modport slave (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, read_data, clk_stall,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, addr, write_data, memread, memwrite, sign_mask
    );
endinterface

// File: rtl/data_mem_initiator.sv
// Load/store initiator: one access in flight, tracks the memory's clk_stall handshake and
// returns exactly one response (load data or error) per accepted request.
module data_mem_initiator #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    data_mem_initiator_if.master bus
);
    localparam int unsigned DW = 32;
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [3:0]    mask_q, mask_d;
    logic          store_q, store_d;
    logic          memread_q, memread_d;
    logic          memwrite_q, memwrite_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_err_q, rsp_err_d;

    logic          ready_c;
    logic          accept_c;
    logic          illegal_c;
    logic          misaligned_c;
    logic [3:0]    mask_c;

    // Never accept while the memory still reports busy, including right after reset
    assign ready_c  = (state_q == IDLE) && !bus.clk_stall;
    assign accept_c = bus.req_valid && ready_c;

    // funct3 decode into legality and the memory's sign_mask encoding
    always_comb begin
        illegal_c = 1'b0;
        mask_c    = 4'b0000;
        case (bus.req_funct3)
            3'd0:    mask_c = bus.req_write ? 4'b0001 : 4'b1001;
            3'd1:    mask_c = bus.req_write ? 4'b0011 : 4'b1011;
            3'd2:    mask_c = 4'b0111;
            3'd4: begin
                mask_c    = 4'b0001;
                illegal_c = bus.req_write;
            end
            3'd5: begin
                mask_c    = 4'b0011;
                illegal_c = bus.req_write;
            end
            default: illegal_c = 1'b1;
        endcase
    end

    assign misaligned_c = ((bus.req_funct3[1:0] == 2'd1) && bus.req_addr[0]) ||
                          ((bus.req_funct3[1:0] == 2'd2) && (bus.req_addr[1:0] != 2'b00));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mask_d      = mask_q;
        store_d     = store_q;
        rdata_d     = '0;
        memread_d   = 1'b0;
        memwrite_d  = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    cnt_d = '0;
                    if (illegal_c || misaligned_c) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        addr_d     = bus.req_addr;
                        wdata_d    = bus.req_wdata;
                        mask_d     = mask_c;
                        store_d    = bus.req_write;
                        memread_d  = !bus.req_write;
                        memwrite_d = bus.req_write;
                        state_d    = ISSUE;
                    end
                end
            end
            ISSUE: state_d = WAIT_HI;
            WAIT_HI, WAIT_LO: begin
                cnt_d = cnt_q + CW'(1);
                // A completing handshake wins over a timeout landing on the same edge
                if ((state_q == WAIT_LO) && !bus.clk_stall) begin
                    rsp_valid_d = 1'b1;
                    rdata_d     = store_q ? '0 : bus.read_data;
                    state_d     = IDLE;
                end else if (cnt_d == CW'(TIMEOUT)) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    state_d     = IDLE;
                end else if ((state_q == WAIT_HI) && bus.clk_stall) begin
                    state_d = WAIT_LO;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            mask_q      <= '0;
            store_q     <= 1'b0;
            memread_q   <= 1'b0;
            memwrite_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            mask_q      <= mask_d;
            store_q     <= store_d;
            memread_q   <= memread_d;
            memwrite_q  <= memwrite_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.req_ready  = ready_c;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_rdata  = rdata_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.addr       = addr_q;
    assign bus.write_data = wdata_q;
    assign bus.memread    = memread_q;
    assign bus.memwrite   = memwrite_q;
    assign bus.sign_mask  = mask_q;
endmodule

// File: tb/tb_data_mem_initiator.sv
// Bench for data_mem_initiator: directed load/store/error/timeout/reset scenarios and random traffic,
// checked against a byte-addressed reference memory and a stalling data-memory model.
module tb_data_mem_initiator;
    localparam int unsigned TIMEOUT = 15;
    localparam int          MAXWAIT = 40;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    data_mem_initiator_if bus ();
    data_mem_initiator #(.TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Data memory: stall high 2 cycles for loads, 1 for stores; mode 1 never stalls, mode 2 stalls forever
    int          mem_mode   = 0;
    int          stall_left = 0;
    logic        stall_r    = 1'b0;
    logic [31:0] rdata_r    = '0;
    logic [31:0] pend_r     = '0;
    logic        mem_loaded = 1'b0;
    logic [31:0] mem_w [0:255];
    logic [7:0]  ref_b [0:1023];

    assign bus.clk_stall = stall_r;
    assign bus.read_data = rdata_r;

    function automatic logic [31:0] mem_extract(input logic [31:0] w, input int sh, input logic [3:0] m);
        logic [31:0] s;
        s = w >> (8 * sh);
        if (!m[1]) return m[3] ? {{24{s[7]}}, s[7:0]} : {24'h0, s[7:0]};
        if (!m[2]) return m[3] ? {{16{s[15]}}, s[15:0]} : {16'h0, s[15:0]};
        return s;
    endfunction

    always @(posedge clk) begin : mem_model
        int sh;
        int idx;
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++)
                mem_w[i] = {ref_b[4*i+3], ref_b[4*i+2], ref_b[4*i+1], ref_b[4*i]};
            mem_loaded <= 1'b1;
        end
        sh  = int'(bus.addr[1:0]);
        idx = int'(bus.addr[9:2]);
        if (mem_mode == 1) begin
            stall_r <= 1'b0;
            stall_left = 0;
        end else if (mem_mode == 2) begin
            stall_r <= 1'b1;
            stall_left = 0;
        end else if (bus.memread) begin
            pend_r  <= mem_extract(mem_w[idx], sh, bus.sign_mask);
            stall_r <= 1'b1;
            stall_left = 2;
        end else if (bus.memwrite) begin
            if (!bus.sign_mask[1]) mem_w[idx][8*sh +: 8] = bus.write_data[7:0];
            else if (!bus.sign_mask[2]) begin
                if (sh < 3) mem_w[idx][8*sh +: 16] = bus.write_data[15:0];
            end else mem_w[idx] = bus.write_data;
            stall_r <= 1'b1;
            stall_left = 1;
        end else if (stall_left > 1) begin
            stall_left = stall_left - 1;
        end else begin
            stall_left = 0;
            if (stall_r) begin
                stall_r <= 1'b0;
                rdata_r <= pend_r;
            end
        end
    end

    // Reference: RV32I load/store semantics on a byte array; lat = edges from accept to response
    task automatic ref_access(input logic wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                              output logic err, output logic [31:0] rd, output logic [3:0] mask, output int lat);
        int  size;
        int  base;
        logic sgn;
        err = 1'b0; rd = '0; mask = 4'b0000; size = 4; sgn = 1'b0; lat = 0;
        case (f3)
            3'd0: begin size = 1; sgn = 1'b1; mask = wr ? 4'b0001 : 4'b1001; end
            3'd1: begin size = 2; sgn = 1'b1; mask = wr ? 4'b0011 : 4'b1011; end
            3'd2: begin size = 4; mask = 4'b0111; end
            3'd4: begin size = 1; mask = 4'b0001; err = wr; end
            3'd5: begin size = 2; mask = 4'b0011; err = wr; end
            default: err = 1'b1;
        endcase
        if (!err && (int'(a[1:0]) % size) != 0) err = 1'b1;
        if (err) return;
        base = int'(a[9:0]);
        if (wr) begin
            for (int i = 0; i < size; i++) ref_b[base+i] = wd[8*i +: 8];
            lat = 3;
        end else begin
            for (int i = 0; i < size; i++) rd[8*i +: 8] = ref_b[base+i];
            if (sgn && size < 4 && rd[8*size-1])
                for (int i = size; i < 4; i++) rd[8*i +: 8] = 8'hFF;
            lat = 4;
        end
    endtask

    // Drive one request, wait for its response; strobes counted from the accept edge onwards
    task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                          output logic got, output logic err, output logic [31:0] rd, output int lat,
                          output int n_rd, output int n_wr, output logic [3:0] mask_seen,
                          output logic [31:0] wdata_seen, output logic dup);
        int guard;
        got = 1'b0; err = 1'b0; rd = '0; lat = -1; n_rd = 0; n_wr = 0;
        mask_seen = '0; wdata_seen = '0; dup = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = wr; bus.req_funct3 = f3;
        bus.req_addr = a; bus.req_wdata = wd;
        guard = 0;
        while (!bus.req_ready && guard < MAXWAIT) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.req_ready) begin
            bus.req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int k = 0; k < MAXWAIT; k++) begin
            if (bus.memread)  n_rd++;
            if (bus.memwrite) n_wr++;
            if (k == 0) begin
                mask_seen  = bus.sign_mask;
                wdata_seen = bus.write_data;
            end
            if (bus.rsp_valid) begin
                got = 1'b1; err = bus.rsp_err; rd = bus.rsp_rdata; lat = k;
                @(negedge clk);
                dup = bus.rsp_valid;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.req_ready); end
        n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        n_tests++; if ({bus.memread, bus.memwrite} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes: got %b want 00", {bus.memread, bus.memwrite}); end
        n_tests++; if (bus.addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", bus.addr); end
        n_tests++; if (bus.sign_mask !== 4'h0) begin n_fail++; $display("FAIL reset_mask: got %b want 0000", bus.sign_mask); end
        n_tests++; if ({bus.rsp_err, bus.rsp_rdata, bus.write_data} !== 65'h0) begin n_fail++; $display("FAIL reset_data: got %b %h %h want 0", bus.rsp_err, bus.rsp_rdata, bus.write_data); end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++; if ({bus.req_ready, bus.rsp_valid} !== 2'b10) begin n_fail++; $display("FAIL reset_release: got %b want 10", {bus.req_ready, bus.rsp_valid}); end
    endtask

    task automatic test_loads();
        logic got, err, dup; logic [31:0] rd, wds; int lat, nr, nw; logic [3:0] ms;
        logic e_err; logic [31:0] e_rd; logic [3:0] e_m; int e_lat;
        ref_access(1'b0, 3'd2, 32'h4000, '0, e_err, e_rd, e_m, e_lat);
        do_req(1'b0, 3'd2, 32'h4000, '0, got, err, rd, lat, nr, nw, ms, wds, dup);
        n_tests++; if ({got, err, dup} !== 3'b100) begin n_fail++; $display("FAIL lw_flags: got v/err/dup %b want 100", {got, err, dup}); end
        n_tests++; if (rd !== 32'h8000_00F1) begin n_fail++; $display("FAIL lw_data: got %h want 800000f1", rd); end
        n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL lw_latency: got %0d want 4", lat); end
        n_tests++; if ({nr, nw} !== {32'd1, 32'd0}) begin n_fail++; $display("FAIL lw_strobes: got rd %0d wr %0d want 1 0", nr, nw); end
        n_tests++; if (ms !== 4'b0111) begin n_fail++; $display("FAIL lw_mask: got %b want 0111", ms); end
        ref_access(1'b0, 3'd0, 32'h4003, '0, e_err, e_rd, e_m, e_lat);
        do_req(1'b0, 3'd0, 32'h4003, '0, got, err, rd, lat, nr, nw, ms, wds, dup);
        n_tests++; if ({got, err, rd} !== {2'b10, 32'hFFFF_FF80}) begin n_fail++; $display("FAIL lb_data: got v %b err %b %h want ffffff80", got, err, rd); end
        n_tests++; if (ms !== 4'b1001) begin n_fail++; $display("FAIL lb_mask: got %b want 1001", ms); end
        ref_access(1'b0, 3'd4, 32'h4003, '0, e_err, e_rd, e_m, e_lat);
        do_req(1'b0, 3'd4, 32'h4003, '0, got, err, rd, lat, nr, nw, ms, wds, dup);
        n_tests++; if ({got, err, rd} !== {2'b10, 32'h0000_0080}) begin n_fail++; $display("FAIL lbu_data: got v %b err %b %h want 00000080", got, err, rd); end
        n_tests++; if (ms !== 4'b0001) begin n_fail++; $display("FAIL lbu_mask: got %b want 0001", ms); end
    endtask

    task automatic test_store_half();
        logic got, err, dup; logic [31:0] rd, wds; int lat, nr, nw; logic [3:0] ms;
        logic e_err; logic [31:0] e_rd; logic [3:0] e_m; int e_lat;
        ref_access(1'b1, 3'd1, 32'h4002, 32'h1234_ABCD, e_err, e_rd, e_m, e_lat);
        do_req(1'b1, 3'd1, 32'h4002, 32'h1234_ABCD, got, err, rd, lat, nr, nw, ms, wds, dup);
        n_tests++; if ({got, err, rd} !== {2'b10, 32'h0}) begin n_fail++; $display("FAIL sh_rsp: got v %b err %b %h want 1 0 0", got, err, rd); end
        n_tests++; if ({nr, nw} !== {32'd0, 32'd1}) begin n_fail++; $display("FAIL sh_strobes: got rd %0d wr %0d want 0 1", nr, nw); end
        n_tests++; if ({ms, wds} !== {4'b0011, 32'h1234_ABCD}) begin n_fail++; $display("FAIL sh_bus: got %b %h want 0011 1234abcd", ms, wds); end
        n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL sh_latency: got %0d want 3", lat); end
        ref_access(1'b0, 3'd5, 32'h4002, '0, e_err, e_rd, e_m, e_lat);
        do_req(1'b0, 3'd5, 32'h4002, '0, got, err, rd, lat, nr, nw, ms, wds, dup);
        n_tests++; if ({got, err, rd} !== {2'b10, 32'h0000_ABCD}) begin n_fail++; $display("FAIL lhu_data: got v %b err %b %h want 0000abcd", got, err, rd); end
    endtask

    task automatic test_errors();
        logic got, err, dup; logic [31:0] rd, wds; int lat, nr, nw; logic [3:0] ms;
        do_req(1'b0, 3'd2, 32'h4001, '0, got, err, rd, lat, nr, nw, ms, wds, dup);
        n_tests++; if ({got, err, rd, dup} !== {2'b11, 32'h0, 1'b0}) begin n_fail++; $display("FAIL lw_misaligned: got v %b err %b %h dup %b want 1 1 0 0", got, err, rd, dup); end
        n_tests++; if ({lat, nr, nw} !== {32'd0, 32'd0, 32'd0}) begin n_fail++; $display("FAIL lw_misaligned_timing: got lat %0d rd %0d wr %0d want 0 0 0", lat, nr, nw); end
        do_req(1'b1, 3'd3, 32'h4000, 32'hDEAD_BEEF, got, err, rd, lat, nr, nw, ms, wds, dup);
        n_tests++; if ({got, err, rd, dup} !== {2'b11, 32'h0, 1'b0}) begin n_fail++; $display("FAIL store_f3_3: got v %b err %b %h dup %b want 1 1 0 0", got, err, rd, dup); end
        n_tests++; if ({lat, nr, nw} !== {32'd0, 32'd0, 32'd0}) begin n_fail++; $display("FAIL store_f3_3_timing: got lat %0d rd %0d wr %0d want 0 0 0", lat, nr, nw); end
    endtask

    task automatic test_timeout();
        logic got, err, dup; logic [31:0] rd, wds; int lat, nr, nw; logic [3:0] ms;
        @(negedge clk);
        mem_mode = 1;
        do_req(1'b0, 3'd2, 32'h4004, '0, got, err, rd, lat, nr, nw, ms, wds, dup);
        n_tests++; if ({got, err, rd, dup} !== {2'b11, 32'h0, 1'b0}) begin n_fail++; $display("FAIL timeout_rsp: got v %b err %b %h dup %b want 1 1 0 0", got, err, rd, dup); end
        n_tests++; if (lat !== 1 + int'(TIMEOUT)) begin n_fail++; $display("FAIL timeout_latency: got %0d want %0d", lat, 1 + int'(TIMEOUT)); end
        n_tests++; if (nr !== 1) begin n_fail++; $display("FAIL timeout_strobe: got %0d want 1", nr); end
        mem_mode = 0;
    endtask

    task automatic test_reset_mid();
        logic got, err, dup; logic [31:0] rd, wds; int lat, nr, nw, guard; logic [3:0] ms;
        logic e_err; logic [31:0] e_rd; logic [3:0] e_m; int e_lat;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_funct3 = 3'd2; bus.req_addr = 32'h4008;
        guard = 0;
        while (!bus.req_ready && guard < MAXWAIT) begin @(negedge clk); guard++; end
        n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_accept: got ready %b want 1", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (bus.clk_stall !== 1'b1) begin n_fail++; $display("FAIL rstmid_stall_up: got %b want 1", bus.clk_stall); end
        mem_mode = 2;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++; if ({bus.memread, bus.memwrite, bus.rsp_valid, bus.req_ready} !== 4'b0000) begin n_fail++; $display("FAIL rstmid_outputs: got rd/wr/rsp/ready %b want 0000", {bus.memread, bus.memwrite, bus.rsp_valid, bus.req_ready}); end
        n_tests++; if ({bus.addr, bus.sign_mask} !== 36'h0) begin n_fail++; $display("FAIL rstmid_async_clear: got %h %b want 0", bus.addr, bus.sign_mask); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_tests++; if ({bus.req_ready, bus.rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL rstmid_gated c%0d: got ready/rsp %b want 00", c, {bus.req_ready, bus.rsp_valid}); end
        end
        mem_mode = 0;
        @(negedge clk);
        n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready_after_stall: got %b want 1", bus.req_ready); end
        ref_access(1'b0, 3'd2, 32'h4008, '0, e_err, e_rd, e_m, e_lat);
        do_req(1'b0, 3'd2, 32'h4008, '0, got, err, rd, lat, nr, nw, ms, wds, dup);
        n_tests++; if ({got, err, rd, lat} !== {1'b1, e_err, e_rd, e_lat}) begin n_fail++; $display("FAIL rstmid_recover: got v %b err %b %h lat %0d want 1 %b %h %0d", got, err, rd, lat, e_err, e_rd, e_lat); end
    endtask

    task automatic test_back_to_back();
        logic        q_wr [3];
        logic [2:0]  q_f3 [3];
        logic [31:0] q_a  [3];
        logic [31:0] q_wd [3];
        logic        exp_err [$];
        logic [31:0] exp_rd  [$];
        logic e_err; logic [31:0] e_rd; logic [3:0] e_m; int e_lat;
        int idx, got, overlap;
        q_wr = '{1'b0, 1'b1, 1'b0};
        q_f3 = '{3'd2, 3'd2, 3'd2};
        q_a  = '{32'h4010, 32'h4014, 32'h4014};
        q_wd = '{32'h0, $urandom, 32'h0};
        idx = 0; got = 0; overlap = 0;
        for (int cyc = 0; cyc < 4 * MAXWAIT && got < 3; cyc++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                got++;
                if (idx < 3 && bus.req_ready) overlap++;
                n_tests++;
                if (exp_rd.size() == 0) begin
                    n_fail++; $display("FAIL b2b_unexpected: got rsp %h with nothing outstanding", bus.rsp_rdata);
                end else begin
                    e_rd = exp_rd.pop_front(); e_err = exp_err.pop_front();
                    if ({bus.rsp_err, bus.rsp_rdata} !== {e_err, e_rd}) begin
                        n_fail++; $display("FAIL b2b_rsp%0d: got err %b %h want %b %h", got, bus.rsp_err, bus.rsp_rdata, e_err, e_rd);
                    end
                end
            end
            if (idx < 3) begin
                bus.req_valid = 1'b1; bus.req_write = q_wr[idx]; bus.req_funct3 = q_f3[idx];
                bus.req_addr = q_a[idx]; bus.req_wdata = q_wd[idx];
                if (bus.req_ready) begin
                    ref_access(q_wr[idx], q_f3[idx], q_a[idx], q_wd[idx], e_err, e_rd, e_m, e_lat);
                    exp_err.push_back(e_err); exp_rd.push_back(e_rd);
                    idx++;
                end
            end else begin
                bus.req_valid = 1'b0;
            end
        end
        bus.req_valid = 1'b0;
        n_tests++; if ({idx, got} !== {32'd3, 32'd3}) begin n_fail++; $display("FAIL b2b_count: got accepted %0d responses %0d want 3 3", idx, got); end
        n_tests++; if (overlap !== 2) begin n_fail++; $display("FAIL b2b_overlap: got %0d accepts in rsp cycle want 2", overlap); end
    endtask

    task automatic test_random();
        logic got, err, dup; logic [31:0] rd, wds; int lat, nr, nw; logic [3:0] ms;
        logic e_err; logic [31:0] e_rd; logic [3:0] e_m; int e_lat;
        logic wr; logic [2:0] f3; logic [31:0] a, wd;
        for (int it = 0; it < 60; it++) begin
            wr = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = 32'h4000 | 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
            wd = $urandom;
            ref_access(wr, f3, a, wd, e_err, e_rd, e_m, e_lat);
            do_req(wr, f3, a, wd, got, err, rd, lat, nr, nw, ms, wds, dup);
            n_tests++;
            if ({got, dup, err, rd, lat} !== {2'b10, e_err, e_rd, e_lat}) begin
                n_fail++; $display("FAIL rand%0d_rsp (wr %b f3 %0d a %h): got v %b dup %b err %b %h lat %0d want 1 0 %b %h %0d",
                                   it, wr, f3, a, got, dup, err, rd, lat, e_err, e_rd, e_lat);
            end
            n_tests++;
            if ({nr, nw} !== {32'(!e_err && !wr), 32'(!e_err && wr)}) begin
                n_fail++; $display("FAIL rand%0d_strobes: got rd %0d wr %0d want %0d %0d", it, nr, nw, !e_err && !wr, !e_err && wr);
            end
            if (!e_err) begin
                n_tests++;
                if (ms !== e_m || (wr && wds !== wd)) begin
                    n_fail++; $display("FAIL rand%0d_bus: got mask %b wdata %h want %b %h", it, ms, wds, e_m, wd);
                end
            end
        end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = 3'd0;
        bus.req_addr = '0; bus.req_wdata = '0;
        for (int i = 0; i < 1024; i++) ref_b[i] = 8'($urandom);
        ref_b[0] = 8'hF1; ref_b[1] = 8'h00; ref_b[2] = 8'h00; ref_b[3] = 8'h80;
        #2 rst_n = 1'b0;
        test_reset();
        test_loads();
        test_store_half();
        test_errors();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
    end
endmodule
